// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async SRAM between a VGA read port (p0)
// and a CPU read/write port (p1). Define SRAM_ARB_RR_EN for round-robin.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = 16,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    io_axiClk,
  input  logic                    io_asyncResetn,
  input  logic                    p0_cmd_valid,
  output logic                    p0_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   p0_cmd_addr,
  output logic                    p0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   p0_rsp_data,
  input  logic                    p1_cmd_valid,
  output logic                    p1_cmd_ready,
  input  logic                    p1_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   p1_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   p1_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_cmd_mask,
  output logic                    p1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   p1_rsp_data,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  input  logic [DATA_WIDTH-1:0]   sram_dq_read,
  output logic [DATA_WIDTH-1:0]   sram_dq_write,
  output logic                    sram_dq_writeEnable,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic                    sram_lb_n,
  output logic                    sram_ub_n
);

  localparam int MW  = DATA_WIDTH / 8;
  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [WCW-1:0]          wcnt_q, wcnt_d;
  logic                    write_q, write_d;
  logic                    port_q, port_d;
  logic [MW-1:0]           mask_q, mask_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   dq_write_q, dq_write_d;
  logic                    dq_we_q, dq_we_d;
  logic                    ce_n_q, ce_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    we_n_q, we_n_d;
  logic                    lb_n_q, lb_n_d;
  logic                    ub_n_q, ub_n_d;
  logic                    p0_rv_q, p0_rv_d;
  logic                    p1_rv_q, p1_rv_d;
  logic [DATA_WIDTH-1:0]   p0_rd_q, p0_rd_d;
  logic [DATA_WIDTH-1:0]   p1_rd_q, p1_rd_d;
  logic                    grant1;
  logic                    idle;
  logic                    take;
  logic                    wr_take;

`ifdef SRAM_ARB_RR_EN
  logic                    last_q, last_d;
`else
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  logic [SCW-1:0]          starve_q, starve_d;
`endif

  // Pick the port that wins a free SRAM this cycle.
  always_comb begin
    grant1 = 1'b0;
    if (p1_cmd_valid && !p0_cmd_valid) begin
      grant1 = 1'b1;
    end else if (p1_cmd_valid && p0_cmd_valid) begin
`ifdef SRAM_ARB_RR_EN
      grant1 = !last_q;
`else
      grant1 = (starve_q == SCW'(STARVE_LIMIT));
`endif
    end
  end

  assign idle         = (state_q == IDLE);
  assign p0_cmd_ready = idle && p0_cmd_valid && !grant1;
  assign p1_cmd_ready = idle && grant1;
  assign take         = p0_cmd_ready || p1_cmd_ready;
  assign wr_take      = p1_cmd_ready && p1_cmd_write;

  // Access sequencing: strobes, data capture and responses.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    write_d    = write_q;
    port_d     = port_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    dq_write_d = dq_write_q;
    dq_we_d    = dq_we_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    lb_n_d     = lb_n_q;
    ub_n_d     = ub_n_q;
    p0_rv_d    = 1'b0;
    p1_rv_d    = 1'b0;
    p0_rd_d    = p0_rd_q;
    p1_rd_d    = p1_rd_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d = ACCESS;
          wcnt_d  = '0;
          write_d = wr_take;
          port_d  = p1_cmd_ready;
          ce_n_d  = 1'b0;
          if (p1_cmd_ready) begin
            addr_d = p1_cmd_addr;
            mask_d = p1_cmd_mask;
          end else begin
            addr_d = p0_cmd_addr;
            mask_d = '1;
          end
          if (wr_take) begin
            dq_write_d = p1_cmd_wdata;
            dq_we_d    = 1'b1;
            we_n_d     = 1'b0;
            oe_n_d     = 1'b1;
            lb_n_d     = ~p1_cmd_mask[0];
            ub_n_d     = ~p1_cmd_mask[MW-1];
          end else begin
            we_n_d = 1'b1;
            oe_n_d = 1'b0;
            lb_n_d = 1'b0;
            ub_n_d = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (wcnt_q == WCW'(WAIT_CYCLES - 1)) begin
          if (write_q) begin
            state_d = RECOVER;
            we_n_d  = 1'b1;
            p1_rv_d = 1'b1;
            p1_rd_d = '0;
          end else begin
            state_d = IDLE;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            lb_n_d  = 1'b1;
            ub_n_d  = 1'b1;
            if (port_q) begin
              p1_rv_d = 1'b1;
              p1_rd_d = sram_dq_read;
            end else begin
              p0_rv_d = 1'b1;
              p0_rd_d = sram_dq_read;
            end
          end
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      RECOVER: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        dq_we_d = 1'b0;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SRAM_ARB_RR_EN
  // Remember which port won last so contention alternates.
  always_comb begin
    last_d = last_q;
    if (take) last_d = p1_cmd_ready;
  end
`else
  // Count p0 wins while p1 is kept waiting.
  always_comb begin
    starve_d = starve_q;
    if (!p1_cmd_valid || p1_cmd_ready) begin
      starve_d = '0;
    end else if (p0_cmd_ready && starve_q != SCW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SCW'(1);
    end
  end
`endif

  // State and registered SRAM/response outputs.
  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      write_q    <= 1'b0;
      port_q     <= 1'b0;
      mask_q     <= '0;
      addr_q     <= '0;
      dq_write_q <= '0;
      dq_we_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
      p0_rv_q    <= 1'b0;
      p1_rv_q    <= 1'b0;
      p0_rd_q    <= '0;
      p1_rd_q    <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q     <= 1'b1;
`else
      starve_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      write_q    <= write_d;
      port_q     <= port_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      dq_write_q <= dq_write_d;
      dq_we_q    <= dq_we_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      lb_n_q     <= lb_n_d;
      ub_n_q     <= ub_n_d;
      p0_rv_q    <= p0_rv_d;
      p1_rv_q    <= p1_rv_d;
      p0_rd_q    <= p0_rd_d;
      p1_rd_q    <= p1_rd_d;
`ifdef SRAM_ARB_RR_EN
      last_q     <= last_d;
`else
      starve_q   <= starve_d;
`endif
    end
  end

  assign sram_addr           = addr_q;
  assign sram_dq_write       = dq_write_q;
  assign sram_dq_writeEnable = dq_we_q;
  assign sram_ce_n           = ce_n_q;
  assign sram_oe_n           = oe_n_q;
  assign sram_we_n           = we_n_q;
  assign sram_lb_n           = lb_n_q;
  assign sram_ub_n           = ub_n_q;
  assign p0_rsp_valid        = p0_rv_q;
  assign p0_rsp_data         = p0_rd_q;
  assign p1_rsp_valid        = p1_rv_q;
  assign p1_rsp_data         = p1_rd_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scoreboard bench with SRAM model and
// reference memory for sram_port_arbiter.
module tb_sram_port_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int W  = 1;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_cmd_valid, p0_cmd_ready;
  logic [AW-1:0] p0_cmd_addr;
  logic          p0_rsp_valid;
  logic [DW-1:0] p0_rsp_data;
  logic          p1_cmd_valid, p1_cmd_ready, p1_cmd_write;
  logic [AW-1:0] p1_cmd_addr;
  logic [DW-1:0] p1_cmd_wdata;
  logic [1:0]    p1_cmd_mask;
  logic          p1_rsp_valid;
  logic [DW-1:0] p1_rsp_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_read, sram_dq_write;
  logic          sram_dq_writeEnable;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  logic          sram_lb_n, sram_ub_n;

  sram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .WAIT_CYCLES(W), .STARVE_LIMIT(SL)
  ) dut (
    .io_axiClk(clk), .io_asyncResetn(rst_n),
    .p0_cmd_valid(p0_cmd_valid), .p0_cmd_ready(p0_cmd_ready),
    .p0_cmd_addr(p0_cmd_addr),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
    .p1_cmd_valid(p1_cmd_valid), .p1_cmd_ready(p1_cmd_ready),
    .p1_cmd_write(p1_cmd_write), .p1_cmd_addr(p1_cmd_addr),
    .p1_cmd_wdata(p1_cmd_wdata), .p1_cmd_mask(p1_cmd_mask),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
    .sram_addr(sram_addr), .sram_dq_read(sram_dq_read),
    .sram_dq_write(sram_dq_write),
    .sram_dq_writeEnable(sram_dq_writeEnable),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n),
    .sram_ub_n(sram_ub_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // SRAM device model (64 words: low 32 and top 32 addresses)
  logic [15:0] sram_mem [0:63];
  logic [5:0]  sram_i;
  assign sram_i = {sram_addr[19], sram_addr[4:0]};
  assign sram_dq_read = (!sram_ce_n && !sram_oe_n) ?
                        sram_mem[sram_i] : 16'hDEAD;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_writeEnable) begin
      if (!sram_lb_n) sram_mem[sram_i][7:0]  <= sram_dq_write[7:0];
      if (!sram_ub_n) sram_mem[sram_i][15:8] <= sram_dq_write[15:8];
    end
  end

  // Reference memory, keyed by full word address
  logic [15:0] ref_mem [logic [19:0]];

  function automatic logic [15:0] ref_rd(logic [19:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a[15:0] ^ 16'h5A3C;
  endfunction

  typedef struct {
    bit          port;
    bit          wr;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  mask;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  bit   glog[$];
  bit   logging = 0;
  logic [15:0] last_p1_rd = '0;

  // Issue side: protocol timing, arbitration rule, expected responses
  bit          act = 0;
  int          t0 = 0;
  int          k;
  bit          cw;
  logic [1:0]  cmask;
  logic [19:0] caddr;
  logic [15:0] cwd;
  int          passed = 0;
  bit          last1 = 1;
  bit          g1, er0, er1, hs0, hs1;
  logic [3:0]  es;
  exp_t        ei;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      act = 0;
      passed = 0;
      last1 = 1;
      sb.delete();
    end else begin
      k = act ? cyc - t0 : 0;
      if (act && k > (cw ? W + 1 : W)) act = 0;
      es = 4'b1110;
      if (act && k <= W) es = cw ? 4'b0101 : 4'b0010;
      else if (act) es = 4'b0111;
      chk("strobes", {sram_ce_n, sram_oe_n, sram_we_n,
                      sram_dq_writeEnable}, es);
      if (act && k <= W) begin
        chk("sram_addr", sram_addr, caddr);
        chk("lanes", {sram_lb_n, sram_ub_n},
            cw ? {~cmask[0], ~cmask[1]} : 2'b00);
      end
      if (act && cw) chk("dq_write", sram_dq_write, cwd);
      er0 = 0;
      er1 = 0;
      if (!act) begin
        if (p0_cmd_valid && p1_cmd_valid) begin
`ifdef SRAM_ARB_RR_EN
          g1 = !last1;
`else
          g1 = (passed == SL);
`endif
        end else begin
          g1 = p1_cmd_valid;
        end
        er0 = p0_cmd_valid && !g1;
        er1 = g1;
      end
      chk("ready", {p0_cmd_ready, p1_cmd_ready}, {er0, er1});
      hs0 = p0_cmd_valid && p0_cmd_ready;
      hs1 = p1_cmd_valid && p1_cmd_ready;
      if (!p1_cmd_valid || hs1) passed = 0;
      else if (hs0 && passed < SL) passed++;
      if (hs0 || hs1) begin
        last1 = hs1;
        ei.port  = hs1;
        ei.wr    = hs1 && p1_cmd_write;
        ei.addr  = hs1 ? p1_cmd_addr : p0_cmd_addr;
        ei.wdata = p1_cmd_wdata;
        ei.mask  = p1_cmd_mask;
        ei.data  = ei.wr ? 16'h0 : ref_rd(ei.addr);
        ei.due   = cyc + W + 1;
        sb.push_back(ei);
        act   = 1;
        t0    = cyc;
        cw    = ei.wr;
        caddr = ei.addr;
        cmask = ei.mask;
        cwd   = ei.wdata;
        if (logging) glog.push_back(hs1);
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response appears
  exp_t        em;
  logic [1:0]  rv;
  logic [15:0] nv;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      rv = {p1_rsp_valid, p0_rsp_valid};
      if (rv != 2'b00) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rv, 2'b00);
        end else begin
          em = sb.pop_front();
          chk("rsp_port", rv, em.port ? 2'b10 : 2'b01);
          chk("rsp_data", em.port ? p1_rsp_data : p0_rsp_data, em.data);
          chk("rsp_cycle", cyc, em.due);
          if (em.port && !em.wr) last_p1_rd = p1_rsp_data;
          if (em.wr) begin
            nv = ref_rd(em.addr);
            if (em.mask[0]) nv[7:0] = em.wdata[7:0];
            if (em.mask[1]) nv[15:8] = em.wdata[15:8];
            ref_mem[em.addr] = nv;
          end
        end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
        chk("rsp_timeout", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  function automatic logic [19:0] raddr();
    logic [19:0] a;
    a = 20'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) a = a | 20'hFFFE0;
    return a;
  endfunction

  task automatic req0(input logic [19:0] a, input int maxw);
    int n = 0;
    p0_cmd_valid = 1;
    p0_cmd_addr = a;
    forever begin
      @(negedge clk);
      if (p0_cmd_ready) break;
      n++;
      if (maxw >= 0 && n > maxw) break;
      if (n > 200) begin
        chk("p0_grant_timeout", n, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    p0_cmd_valid = 0;
    p0_cmd_addr = 20'($urandom);
  endtask

  task automatic req1(input bit wr, input logic [19:0] a,
                      input logic [15:0] wd, input logic [1:0] m,
                      input int maxw);
    int n = 0;
    p1_cmd_valid = 1;
    p1_cmd_write = wr;
    p1_cmd_addr = a;
    p1_cmd_wdata = wd;
    p1_cmd_mask = m;
    forever begin
      @(negedge clk);
      if (p1_cmd_ready) break;
      n++;
      if (maxw >= 0 && n > maxw) break;
      if (n > 200) begin
        chk("p1_grant_timeout", n, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    p1_cmd_valid = 0;
    p1_cmd_write = 1'($urandom);
    p1_cmd_addr = 20'($urandom);
    p1_cmd_wdata = 16'($urandom);
    p1_cmd_mask = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] a;
    int n;
    for (int i = 0; i < 64; i++) begin
      a = (i < 32) ? 20'(i) : 20'hFFFE0 + 20'(i - 32);
      sram_mem[i] = a[15:0] ^ 16'h5A3C;
    end
    sram_mem[6'h10] = 16'hBEEF;
    ref_mem[20'h00010] = 16'hBEEF;
    sram_mem[6'h3F] = 16'hAB55;
    ref_mem[20'hFFFFF] = 16'hAB55;
    p0_cmd_valid = 0;
    p0_cmd_addr = '0;
    p1_cmd_valid = 0;
    p1_cmd_write = 0;
    p1_cmd_addr = '0;
    p1_cmd_wdata = '0;
    p1_cmd_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n,
                        sram_lb_n, sram_ub_n}, 5'h1F);
    chk("rst_dq_we", sram_dq_writeEnable, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_write", sram_dq_write, 0);
    chk("rst_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
    chk("rst_rsp_data", {p0_rsp_data, p1_rsp_data}, 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    req0(20'h00010, -1);
    drain();

    req1(1, 20'hFFFFF, 16'h1234, 2'b10, -1);
    drain();
    req1(0, 20'hFFFFF, 16'h0, 2'b00, -1);
    drain();
    chk("readback_fffff", last_p1_rd, 16'h1255);

    glog.delete();
    logging = 1;
    fork
      begin
        repeat (12) req0(raddr(), -1);
      end
      begin
        repeat (3) req1(0, raddr(), 16'h0, 2'b00, -1);
      end
    join
    logging = 0;
    drain();
`ifdef SRAM_ARB_RR_EN
    n = 6;
`else
    n = 15;
`endif
    chk("grant_log_len", glog.size(), 15);
    for (int i = 0; i < n && i < glog.size(); i++) begin
`ifdef SRAM_ARB_RR_EN
      chk("grant_order", glog[i], (i % 2) == 1);
`else
      chk("grant_order", glog[i], (i % 5) == 4);
`endif
    end

    repeat (6) req0(raddr(), -1);
    drain();

    p1_cmd_valid = 1;
    p1_cmd_write = 1;
    p1_cmd_addr = 20'h00005;
    p1_cmd_wdata = 16'hCAFE;
    p1_cmd_mask = 2'b11;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!p1_cmd_ready && n < 50);
    if (!p1_cmd_ready) chk("t5_grant", 0, 1);
    @(posedge clk);
    #1;
    p1_cmd_valid = 0;
    chk("t5_in_access", {sram_ce_n, sram_we_n,
                         sram_dq_writeEnable}, 3'b001);
    #1;
    rst_n = 0;
    #1;
    chk("t5_abort", {sram_ce_n, sram_we_n,
                     sram_dq_writeEnable}, 3'b110);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    req1(0, 20'h00005, 16'h0, 2'b00, -1);
    drain();
    chk("t5_not_written", last_p1_rd, 16'h5A39);
    req0(20'h00010, -1);
    drain();

    fork
      begin
        repeat (60) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          req0(raddr(), ($urandom_range(0, 5) == 0) ?
                        int'($urandom_range(0, 2)) : -1);
        end
      end
      begin
        repeat (60) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          req1(1'($urandom), raddr(), 16'($urandom), 2'($urandom),
               ($urandom_range(0, 5) == 0) ?
               int'($urandom_range(0, 2)) : -1);
        end
      end
    join
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
